// File: rtl/mac_acc_block.sv
// rtl/mac_acc_block.sv - MAC output-side product accumulator with valid/ready result handshake
//
// Purpose: accepts per-cycle product words from the MAC multiply stage and
// masks each one to the Single/Dual/Quad product width. It sums len products
// and presents the sum on a valid/ready output. The output is held until it
// is accepted.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   en         in   clock enable; low freezes all state and forces in_ready low
//   cfg        in   [MAC_CONF_WIDTH] mode select, cfg[1:0] = Single/Dual/Quad
//   len        in   [MAC_CNT_WIDTH] products per accumulation (0 treated as 1)
//   in_valid   in   product word valid
//   in_data    in   [MAC_INT_WIDTH] product word
//   in_ready   out  product word accepted this cycle (with in_valid and en)
//   out_valid  out  out_data holds a completed sum
//   out_ready  in   downstream accepts out_data
//   out_data   out  [MAC_ACC_WIDTH] accumulated sum
//   overflow   out  sticky carry-out of the current/held sum
//   busy       out  accumulation in progress or result held
module mac_acc_block #(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = 6 * MAC_MIN_WIDTH,
    parameter int MAC_CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [MAC_CONF_WIDTH-1:0] cfg,
    input  logic [MAC_CNT_WIDTH-1:0]  len,
    input  logic                      in_valid,
    input  logic [MAC_INT_WIDTH-1:0]  in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAC_ACC_WIDTH-1:0]  out_data,
    output logic                      overflow,
    output logic                      busy
);

    // cfg[1:0] mode encodings; 2'b11 is reserved
    localparam logic [1:0] MAC_SINGLE = 2'b00;
    localparam logic [1:0] MAC_DUAL   = 2'b01;
    localparam logic [1:0] MAC_QUAD   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_HOLD  = 2'b10
    } state_t;

    state_t                     state_q, state_d;
    logic [MAC_ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [MAC_CNT_WIDTH-1:0]   count_q, count_d;
    logic [MAC_CNT_WIDTH-1:0]   len_q, len_d;
    logic [1:0]                 cfg_q, cfg_d;
    logic                       ovf_q, ovf_d;

    logic                       in_fire;
    logic [1:0]                 beat_cfg;
    logic [MAC_ACC_WIDTH-1:0]   beat_val;
    logic [MAC_ACC_WIDTH-1:0]   sum;
    logic                       carry;
    logic [MAC_CNT_WIDTH-1:0]   len_eff;
    logic [MAC_CNT_WIDTH-1:0]   count_inc;

    function automatic logic [MAC_ACC_WIDTH-1:0] mask_beat(
        input logic [1:0]               sel,
        input logic [MAC_INT_WIDTH-1:0] data
    );
        logic [MAC_ACC_WIDTH-1:0] m;
        m = '0;
        case (sel)
            MAC_SINGLE: m[2*MAC_MIN_WIDTH-1:0] = '1;
            MAC_DUAL:   m[3*MAC_MIN_WIDTH-1:0] = '1;
            MAC_QUAD:   m[5*MAC_MIN_WIDTH-1:0] = '1;
            default:    m = '0;   // reserved mode contributes zero but still counts
        endcase
        return MAC_ACC_WIDTH'(data) & m;
    endfunction

    assign in_ready  = en && (state_q != S_HOLD);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = acc_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != S_IDLE);

    // The first beat is masked by the live cfg since it is latched on that same edge
    assign beat_cfg  = (state_q == S_IDLE) ? cfg[1:0] : cfg_q;
    assign beat_val  = mask_beat(beat_cfg, in_data);
    assign {carry, sum} = {1'b0, acc_q} + {1'b0, beat_val};
    assign len_eff   = (len == '0) ? MAC_CNT_WIDTH'(1) : len;
    assign count_inc = count_q + MAC_CNT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        cfg_d   = cfg_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    cfg_d   = cfg[1:0];
                    len_d   = len_eff;
                    acc_d   = beat_val;
                    count_d = MAC_CNT_WIDTH'(1);
                    ovf_d   = 1'b0;
                    state_d = (len_eff == MAC_CNT_WIDTH'(1)) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_fire) begin
                    acc_d   = sum;
                    count_d = count_inc;
                    ovf_d   = ovf_q | carry;
                    if (count_inc == len_q) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (en && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            cfg_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            cfg_q   <= cfg_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_acc_block.sv
// tb/tb_mac_acc_block.sv - directed self-checking bench for mac_acc_block
module tb_mac_acc_block;

    localparam int CW  = 3;
    localparam int MW  = 8;
    localparam int IW  = 5 * MW;
    localparam int AW  = 6 * MW;
    localparam int NW  = 9;   // wide enough for the 257-beat overflow run

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CW-1:0] cfg;
    logic [NW-1:0] len;
    logic          in_valid;
    logic [IW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          overflow;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    mac_acc_block #(
        .MAC_CONF_WIDTH(CW),
        .MAC_MIN_WIDTH (MW),
        .MAC_INT_WIDTH (IW),
        .MAC_ACC_WIDTH (AW),
        .MAC_CNT_WIDTH (NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg      (cfg),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [IW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; cfg = '0; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Single, len=3
        cfg = 3'b000; len = 9'd3;
        beat(40'h00_0001_FFFF);
        chk("single_busy", 64'(busy), 64'd1);
        beat(40'h00_0000_0002);
        chk("single_not_yet", 64'(out_valid), 64'd0);
        beat(40'h00_0000_0003);
        chk("single_valid",    64'(out_valid), 64'd1);
        chk("single_data",     64'(out_data),  64'h1_0004);
        chk("single_ovf",      64'(overflow),  64'd0);
        chk("single_in_ready", 64'(in_ready),  64'd0);
        drain();
        chk("single_drained", 64'(out_valid), 64'd0);
        chk("idle_in_ready",  64'(in_ready),  64'd1);

        // Dual, len=2
        cfg = 3'b001; len = 9'd2;
        beat(40'hFF_FFFF_FFFF);
        beat(40'h00_0000_0001);
        chk("dual_valid", 64'(out_valid), 64'd1);
        chk("dual_data",  64'(out_data),  64'h100_0000);
        drain();

        // Quad, len=0 acts as 1; hold for 5 cycles
        cfg = 3'b010; len = 9'd0;
        beat(40'hFE_01FE_01FE);
        chk("quad_valid", 64'(out_valid), 64'd1);
        chk("quad_data",  64'(out_data),  64'hFE_01FE_01FE);
        in_valid = 1'b1; in_data = 40'h11;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_data",     64'(out_data),  64'hFE_01FE_01FE);
            chk("hold_valid",    64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready),  64'd0);
        end
        in_valid = 1'b0;
        drain();
        chk("quad_idle_busy", 64'(busy), 64'd0);

        // Overflow: 257 beats of 2^40-1 wrap to 2^40-257
        cfg = 3'b010; len = 9'd257;
        for (int i = 0; i < 257; i++) begin
            beat(40'hFF_FFFF_FFFF);
        end
        chk("ovf_valid", 64'(out_valid), 64'd1);
        chk("ovf_data",  64'(out_data),  64'h00FF_FFFF_FEFF);
        chk("ovf_flag",  64'(overflow),  64'd1);
        drain();
        chk("ovf_sticky_idle", 64'(overflow), 64'd1);
        cfg = 3'b000; len = 9'd1;
        beat(40'd5);
        chk("after_ovf_data", 64'(out_data), 64'd5);
        chk("after_ovf_flag", 64'(overflow), 64'd0);
        drain();

        // Reserved mode: beats contribute zero but are counted
        cfg = 3'b011; len = 9'd2;
        beat(40'hFF);
        beat(40'h01);
        chk("rsv_valid", 64'(out_valid), 64'd1);
        chk("rsv_data",  64'(out_data),  64'd0);
        drain();

        // en gating, bubbles and mid-run cfg change
        cfg = 3'b000; len = 9'd3;
        beat(40'd10);
        en = 1'b0; in_valid = 1'b1; in_data = 40'd100;
        #1;
        chk("en0_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("en0_busy",  64'(busy),      64'd1);
        chk("en0_valid", 64'(out_valid), 64'd0);
        en = 1'b1; in_valid = 1'b0;
        tick();
        cfg = 3'b010;
        beat(40'h1_2345);
        chk("gate_not_yet", 64'(out_valid), 64'd0);
        beat(40'h1_0001);
        chk("gate_valid", 64'(out_valid), 64'd1);
        chk("gate_data",  64'(out_data),  64'h2350);
        en = 1'b0; out_ready = 1'b1;
        tick();
        chk("en0_hold", 64'(out_valid), 64'd1);
        en = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("gate_drained", 64'(out_valid), 64'd0);

        // Async reset mid-ACCUM (2 of 4 beats)
        cfg = 3'b000; len = 9'd4;
        beat(40'd1);
        beat(40'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",     64'(busy),      64'd0);
        chk("arst_data",     64'(out_data),  64'd0);
        chk("arst_valid",    64'(out_valid), 64'd0);
        chk("arst_overflow", 64'(overflow),  64'd0);
        tick();
        rst = 1'b0;
        tick();
        cfg = 3'b000; len = 9'd1;
        beat(40'd7);
        chk("post_arst_valid", 64'(out_valid), 64'd1);
        chk("post_arst_data",  64'(out_data),  64'd7);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
